// File: rtl/mseq_code_gen.sv
`default_nettype none
// ============================================================================
// Module      : mseq_code_gen
// Description : PN127 m-sequence serial code generator for the 2FSK modulator.
//               A 7-bit Fibonacci LFSR (x^7+x^6+1) is stepped once every
//               CLK_DIV clock cycles. The module also drives bit and frame
//               strobes and the index of the current bit.
//               Optional macro MSEQ_DIFF_EN selects NRZ-M differential
//               encoding of the serial output.
// Revision    : 1.0 - initial release
// ============================================================================
module mseq_code_gen #(
    parameter int unsigned CLK_DIV   = 500000,
    parameter logic [6:0]  LFSR_SEED = 7'h7F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       m_ser_code_out,
    output logic       bit_strobe,
    output logic       frame_sync,
    output logic [6:0] bit_cnt
);

    // An all-zero seed would lock the LFSR, so it is replaced by 7'h01.
    localparam logic [6:0]  c_seed     = (LFSR_SEED == 7'h00) ? 7'h01 : LFSR_SEED;
    localparam logic [19:0] c_div_last = 20'(CLK_DIV - 1);
    localparam logic [6:0]  c_last_bit = 7'd126;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic [19:0] div_cnt_q, div_cnt_d;
    logic        ser_q, ser_d;
    logic        strobe_q, strobe_d;
    logic        frame_q, frame_d;
    logic [6:0]  cnt_q, cnt_d;

    logic        w_tick;
    logic        w_next_bit;

    // One LFSR step. The zero state cannot occur in normal operation, so
    // leaving it through 7'h01 only matters after an upset.
    function automatic logic [6:0] lfsr_step(input logic [6:0] v);
        if (v == 7'h00) begin
            return 7'h01;
        end
        return {v[5:0], v[6] ^ v[5]};
    endfunction

    // Choose the value of the next output bit: raw LFSR bit or NRZ-M encoded.
    always_comb begin
        w_tick = (div_cnt_q == c_div_last);
`ifdef MSEQ_DIFF_EN
        w_next_bit = ser_q ^ lfsr_q[6];
`else
        w_next_bit = lfsr_q[6];
`endif
    end

    // Next-state and output logic for the IDLE/RUN controller.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        div_cnt_d = div_cnt_q;
        ser_d     = ser_q;
        strobe_d  = 1'b0;
        frame_d   = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                lfsr_d    = c_seed;
                div_cnt_d = 20'd0;
                ser_d     = 1'b0;
                cnt_d     = 7'd0;
                if (en) begin
                    // Bit 0 is presented straight from the seed. The encoder
                    // history is zero here, so bit 0 equals the raw bit in
                    // both output modes.
                    state_d  = RUN;
                    ser_d    = c_seed[6];
                    strobe_d = 1'b1;
                    frame_d  = 1'b1;
                    lfsr_d   = lfsr_step(c_seed);
                end
            end
            RUN: begin
                if (!en) begin
                    // Stopping discards any tick that falls on the same edge.
                    state_d   = IDLE;
                    lfsr_d    = c_seed;
                    div_cnt_d = 20'd0;
                    ser_d     = 1'b0;
                    cnt_d     = 7'd0;
                end else if (w_tick) begin
                    div_cnt_d = 20'd0;
                    ser_d     = w_next_bit;
                    lfsr_d    = lfsr_step(lfsr_q);
                    strobe_d  = 1'b1;
                    cnt_d     = (cnt_q == c_last_bit) ? 7'd0 : cnt_q + 7'd1;
                    frame_d   = (cnt_q == c_last_bit);
                end else begin
                    div_cnt_d = div_cnt_q + 20'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset takes priority over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= c_seed;
            div_cnt_q <= 20'd0;
            ser_q     <= 1'b0;
            strobe_q  <= 1'b0;
            frame_q   <= 1'b0;
            cnt_q     <= 7'd0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            div_cnt_q <= div_cnt_d;
            ser_q     <= ser_d;
            strobe_q  <= strobe_d;
            frame_q   <= frame_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_ser_code_out = ser_q;
    assign bit_strobe     = strobe_q;
    assign frame_sync     = frame_q;
    assign bit_cnt        = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mseq_code_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_mseq_code_gen
// Description : Self-checking bench for mseq_code_gen. Four instances with
//               different CLK_DIV / LFSR_SEED values share clk, rst and en.
//               Expected outputs come from the sequence recurrence
//               b[k+7] = b[k] ^ b[k+1] and a cycle count since run start.
//               Honours MSEQ_DIFF_EN in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mseq_code_gen;

    localparam int N = 4;

    function automatic int div_of(input int i);
        case (i)
            0: return 4;
            1: return 5;
            2: return 1;
            default: return 3;
        endcase
    endfunction

    // Effective seed (instance 3 is built with 7'h00, which acts as 7'h01).
    function automatic logic [6:0] seed_of(input int i);
        return (i == 3) ? 7'h01 : 7'h7F;
    endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ser [N];
    logic       bs  [N];
    logic       fs  [N];
    logic [6:0] bc  [N];

    always #5 clk = ~clk;

    mseq_code_gen #(.CLK_DIV(4), .LFSR_SEED(7'h7F)) u_div4 (
        .clk(clk), .rst(rst), .en(en), .m_ser_code_out(ser[0]),
        .bit_strobe(bs[0]), .frame_sync(fs[0]), .bit_cnt(bc[0]));
    mseq_code_gen #(.CLK_DIV(5), .LFSR_SEED(7'h7F)) u_div5 (
        .clk(clk), .rst(rst), .en(en), .m_ser_code_out(ser[1]),
        .bit_strobe(bs[1]), .frame_sync(fs[1]), .bit_cnt(bc[1]));
    mseq_code_gen #(.CLK_DIV(1), .LFSR_SEED(7'h7F)) u_div1 (
        .clk(clk), .rst(rst), .en(en), .m_ser_code_out(ser[2]),
        .bit_strobe(bs[2]), .frame_sync(fs[2]), .bit_cnt(bc[2]));
    mseq_code_gen #(.CLK_DIV(3), .LFSR_SEED(7'h00)) u_seed0 (
        .clk(clk), .rst(rst), .en(en), .m_ser_code_out(ser[3]),
        .bit_strobe(bs[3]), .frame_sync(fs[3]), .bit_cnt(bc[3]));

    // Reference model state.
    bit seqb [N][127];
    bit pfx  [N][127];
    bit par  [N];
    bit running;
    int t;
    int cyc;
    int last_fs;
    bit cap_on;
    bit cap  [N][128];

    int n_assert = 0;
    int n_fail   = 0;

    function automatic void build_model();
        bit acc;
        for (int i = 0; i < N; i++) begin
            logic [6:0] s;
            s = seed_of(i);
            for (int j = 0; j < 7; j++) seqb[i][j] = s[6 - j];
            for (int j = 7; j < 127; j++) seqb[i][j] = seqb[i][j - 7] ^ seqb[i][j - 6];
            acc = 1'b0;
            for (int j = 0; j < 127; j++) begin
                acc = acc ^ seqb[i][j];
                pfx[i][j] = acc;
            end
            par[i] = acc;
        end
    endfunction

    function automatic bit exp_bit(input int i, input int k);
`ifdef MSEQ_DIFF_EN
        return pfx[i][k % 127] ^ (par[i] & ((k / 127) % 2 == 1));
`else
        return seqb[i][k % 127];
`endif
    endfunction

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            logic       e_ser, e_bs, e_fs;
            logic [6:0] e_bc;
            int d, k;
            d = div_of(i);
            if (running) begin
                k     = t / d;
                e_ser = exp_bit(i, k);
                e_bs  = (t % d == 0);
                e_fs  = (t % d == 0) && (k % 127 == 0);
                e_bc  = 7'(k % 127);
            end else begin
                e_ser = 1'b0; e_bs = 1'b0; e_fs = 1'b0; e_bc = 7'd0;
            end
            n_assert++;
            assert (ser[i] === e_ser) else begin
                n_fail++;
                $error("FAIL ser[%0d] cyc=%0d observed=%b expected=%b", i, cyc, ser[i], e_ser);
            end
            n_assert++;
            assert (bs[i] === e_bs) else begin
                n_fail++;
                $error("FAIL bit_strobe[%0d] cyc=%0d observed=%b expected=%b", i, cyc, bs[i], e_bs);
            end
            n_assert++;
            assert (fs[i] === e_fs) else begin
                n_fail++;
                $error("FAIL frame_sync[%0d] cyc=%0d observed=%b expected=%b", i, cyc, fs[i], e_fs);
            end
            n_assert++;
            assert (bc[i] === e_bc) else begin
                n_fail++;
                $error("FAIL bit_cnt[%0d] cyc=%0d observed=%0d expected=%0d", i, cyc, bc[i], e_bc);
            end
        end
    endtask

    // Advance one clock: update the model from the sampled rst/en, then
    // check every instance on the falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) running = 1'b0;
        else if (!running && en) begin running = 1'b1; t = 0; end
        else if (running && !en) running = 1'b0;
        else if (running) t++;
        @(negedge clk);
        check_all();
        if (!running) last_fs = -1;
        if (fs[0] === 1'b1) begin
            if (last_fs >= 0) begin
                n_assert++;
                assert (cyc - last_fs == 508) else begin
                    n_fail++;
                    $error("FAIL frame_spacing cyc=%0d observed=%0d expected=508", cyc, cyc - last_fs);
                end
            end
            last_fs = cyc;
        end
        if (cap_on && running) begin
            for (int i = 0; i < N; i++) begin
                if ((t % div_of(i) == 0) && (t / div_of(i) < 128)) cap[i][t / div_of(i)] = ser[i];
            end
        end
    endtask

    task automatic clear_cap();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 128; j++) cap[i][j] = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_a;
        logic [6:0] exp_d;
        rst = 1'b1; en = 1'b1;
        running = 1'b0; t = 0; cyc = 0; last_fs = -1; cap_on = 1'b0;
        build_model();
        clear_cap();
`ifdef MSEQ_DIFF_EN
        exp_a = 8'b1010_1011;
`else
        exp_a = 8'b1111_1110;
`endif
        exp_d = 7'b000_0001;

        @(negedge clk);
        // Reset held with en=1.
        for (int n = 0; n < 3; n++) step();
        for (int i = 0; i < N; i++) begin
            n_assert++;
            assert ({ser[i], bs[i], fs[i], bc[i]} === 10'd0) else begin
                n_fail++;
                $error("FAIL reset_idle[%0d] observed=%b expected=0", i, {ser[i], bs[i], fs[i], bc[i]});
            end
        end

        // Release reset: first bit one cycle later.
        rst = 1'b0; cap_on = 1'b1;
        step();
        n_assert++;
        assert ({bs[0], fs[0], bc[0]} === {1'b1, 1'b1, 7'd0}) else begin
            n_fail++;
            $error("FAIL start_latency observed=%b/%b/%0d expected=1/1/0", bs[0], fs[0], bc[0]);
        end

        // Long run: two full frames for CLK_DIV=4, one for the others.
        for (int n = 0; n < 1100; n++) step();
        cap_on = 1'b0;
        for (int j = 0; j < 8; j++) begin
            n_assert++;
            assert (cap[0][j] === exp_a[7 - j]) else begin
                n_fail++;
                $error("FAIL first_bits_7f bit%0d observed=%b expected=%b", j, cap[0][j], exp_a[7 - j]);
            end
        end
        n_assert++;
        assert (cap[0][127] === cap[0][0]) else begin
            n_fail++;
            $error("FAIL bit127_eq_bit0 observed=%b expected=%b", cap[0][127], cap[0][0]);
        end
        for (int j = 0; j < 7; j++) begin
            n_assert++;
            assert (cap[3][j] === exp_d[6 - j]) else begin
                n_fail++;
                $error("FAIL first_bits_seed0 bit%0d observed=%b expected=%b", j, cap[3][j], exp_d[6 - j]);
            end
        end

        // Stop at bit 40 of the CLK_DIV=4 instance, mid-bit.
        en = 1'b0; step();
        en = 1'b1; step();
        for (int n = 0; n < 400 && t < 162; n++) step();
        en = 1'b0; step();
        for (int i = 0; i < N; i++) begin
            n_assert++;
            assert ({ser[i], bs[i], fs[i], bc[i]} === 10'd0) else begin
                n_fail++;
                $error("FAIL stop_outputs[%0d] observed=%b expected=0", i, {ser[i], bs[i], fs[i], bc[i]});
            end
        end

        // Restart: sequence starts again from bit 0.
        clear_cap(); cap_on = 1'b1;
        en = 1'b1; step();
        n_assert++;
        assert (bc[0] === 7'd0 && bs[0] === 1'b1) else begin
            n_fail++;
            $error("FAIL restart_cnt observed=%0d/%b expected=0/1", bc[0], bs[0]);
        end
        for (int n = 0; n < 40; n++) step();
        cap_on = 1'b0;
        for (int j = 0; j < 3; j++) begin
            n_assert++;
            assert (cap[0][j] === exp_a[7 - j]) else begin
                n_fail++;
                $error("FAIL restart_bits bit%0d observed=%b expected=%b", j, cap[0][j], exp_a[7 - j]);
            end
        end

        // Randomised en drops and reset pulses.
        for (int r = 0; r < 12; r++) begin
            int len;
            len = $urandom_range(600, 20);
            for (int n = 0; n < len; n++) begin
                rst = ($urandom_range(99, 0) < 1);
                en  = ($urandom_range(99, 0) >= 3);
                step();
            end
            rst = 1'b0; en = 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mseq_code_gen.md
# mseq_code_gen

Baseband source for the 2FSK modulator. Produces a 127-bit maximal-length (m-sequence, PN127) serial code at a programmable bit rate. The serial bit drives the modulator's carrier-select input, where 1 selects the 10 kHz carrier and 0 selects the 1 kHz carrier. Also emits per-bit and per-frame strobes for the bench, the display and downstream framing logic.

## Interface
Parameters:
- CLK_DIV, 500000: `clk` cycles per code bit (100 bit/s at 50 MHz); legal range 1..2^20-1.
- LFSR_SEED, 7'h7F: LFSR load value at run start; 7'h00 is replaced by 7'h01.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  level run enable; 1 = generate, 0 = stop and clear.
- m_ser_code_out  output  1  serial code bit, held for CLK_DIV cycles per bit.
- bit_strobe  output  1  one-cycle pulse in the cycle a new bit first appears on m_ser_code_out.
- frame_sync  output  1  one-cycle pulse coincident with bit_strobe of bit 0 of each 127-bit period.
- bit_cnt  output  7  index of the bit currently on m_ser_code_out, 0..126.

## Operation
- Two states, IDLE and RUN.
- LFSR:
  - 7-bit Fibonacci, polynomial x^7+x^6+1.
  - Raw bit = lfsr[6].
  - Shift: lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}.
  - Period 127.
- Divider: 20-bit div_cnt counts 0..CLK_DIV-1 in RUN. The terminal count (div_cnt==CLK_DIV-1) is the bit tick, and div_cnt returns to 0.
- IDLE:
  - lfsr = seed, div_cnt = 0.
  - All outputs 0.
  - Transitions to RUN when en=1.
  - Transition cycle (entering RUN): m_ser_code_out <= seed[6], bit_strobe <= 1, frame_sync <= 1, bit_cnt <= 0. The LFSR shifts once so it holds the next bit.
- RUN, on each tick:
  - m_ser_code_out <= lfsr[6]; LFSR shifts.
  - bit_strobe <= 1.
  - bit_cnt increments, wrapping 126 -> 0. frame_sync <= 1 when the new bit_cnt is 0.
- RUN, not on a tick: bit_strobe and frame_sync are 0, and all other registers hold.
- RUN -> IDLE when en=0. The next cycle shows IDLE values (outputs 0, lfsr re-seeded). A later en=1 restarts from bit 0; the sequence does not resume.
- Lock-up guard: if lfsr is ever 7'h00, the next value is 7'h01 (only reachable by an upset).
- Reset overrides en. rst=1 forces IDLE in the next cycle from any state, including mid-bit.
- CLK_DIV=1: every RUN cycle is a tick, so bit_strobe stays high continuously and the bit changes every cycle.

## Timing
- Reset values: m_ser_code_out=0, bit_strobe=0, frame_sync=0, bit_cnt=0, state IDLE.
- All outputs are registered; there are no combinational paths from en to any output.
- Start latency: en sampled 1 at edge N (in IDLE) -> first bit, bit_strobe and frame_sync valid after edge N+1.
- Bit spacing: consecutive bit_strobe pulses are exactly CLK_DIV cycles apart. The first RUN bit is also held for CLK_DIV cycles.
- Frame spacing: frame_sync pulses are 127*CLK_DIV cycles apart.
- Stop latency: en sampled 0 at edge N -> outputs 0 after edge N+1. A tick on the same edge is discarded.

## Configuration
- MSEQ_DIFF_EN defined:
  - m_ser_code_out carries differentially encoded (NRZ-M) data: out <= out_prev ^ raw on each bit.
  - out_prev is cleared to 0 at IDLE->RUN, so bit 0 = raw bit 0.
  - Strobes, bit_cnt and timing are unchanged.
- MSEQ_DIFF_EN undefined: m_ser_code_out = raw LFSR bit, and no encoder register exists.

## Test plan
- Reset/idle: rst=1 for 3 cycles with en=1 -> all outputs 0. Release rst with en=1 -> bit_strobe and frame_sync high exactly 1 cycle later, bit_cnt=0.
- Sequence check, CLK_DIV=4, seed 7'h7F:
  - Raw output bits 0..7 = 1,1,1,1,1,1,1,0.
  - 127 bits match a reference LFSR model; bit 127 equals bit 0.
  - frame_sync repeats every 508 cycles.
- Bit period, CLK_DIV=5: every bit is held exactly 5 cycles and bit_strobe is spaced 5 cycles. CLK_DIV=1: output changes every cycle and bit_strobe stays at 1.
- Stop/restart: drop en at bit 40 mid-period -> outputs 0 the next cycle. Re-assert en -> bit_cnt restarts at 0 with bit pattern 1,1,1,...
- Seed 0: LFSR_SEED=7'h00 -> behaves as seed 7'h01; first bits 0,0,0,0,0,0,1; never sticks at 0.
- MSEQ_DIFF_EN build, seed 7'h7F: encoded bits 0..7 = 1,0,1,0,1,0,1,1.
